// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO.
// Holds the storage array, binary read/write pointers, full/empty flags,
// an occupancy count and almost-full/almost-empty thresholds.
// The read side is either registered (FWFT=0) or first-word-fall-through (FWFT=1).
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
//
// Handshake: w_en is "valid" on the write side and !full is its "ready".
// r_en is "valid" on the read side and !empty is its "ready".
// A transfer happens on a posedge where valid and ready are both high.
// Ready comes only from registered pointers, so it never depends on valid.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  // Out-of-range parameters are a configuration error. Elaboration stops here.
  if (DEPTH < 2 || DEPTH != (1 << PTR_WIDTH) ||
      AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1 ||
      (FWFT != 0 && FWFT != 1)) begin : g_param_err
    $fatal(1, "sync_fifo_param: illegal parameter combination");
  end

  localparam logic [PTR_WIDTH:0] AF_T = (PTR_WIDTH + 1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_T = (PTR_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wptr_q;
  logic [PTR_WIDTH:0]    rptr_q;
  logic [PTR_WIDTH-1:0]  waddr;
  logic [PTR_WIDTH-1:0]  raddr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign waddr = wptr_q[PTR_WIDTH-1:0];
  assign raddr = rptr_q[PTR_WIDTH-1:0];

  // Flags and count decode the pointer registers only.
  // They therefore change only after a clock edge.
  always_comb begin
    count        = wptr_q - rptr_q;
    empty        = (wptr_q == rptr_q);
    full         = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                   (waddr == raddr);
    almost_full  = (count >= AF_T);
    almost_empty = (count <= AE_T);
    wr_ok        = w_en && !full;
    rd_ok        = r_en && !empty;
  end

  // Pointer registers. They wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array. It has no reset; a reset simply makes every entry stale.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[waddr] <= data_in;
  end

  if (FWFT == 0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] dout_q;
    // Registered read: the head word is captured on the edge that pops it.
    always_ff @(posedge clk) begin
      if (rst)        dout_q <= '0;
      else if (rd_ok) dout_q <= mem[raddr];
    end
    assign data_out = dout_q;
  end else begin : g_fwft_read
    // Fall-through: the head word is always shown; r_en acknowledges it.
    assign data_out = mem[raddr];
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags for rejected accesses, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: checks a registered-read instance and an FWFT instance.
// Both instances share one stimulus stream and one queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] dout0, dout1;
  logic          full0, empty0, af0, ae0;
  logic          full1, empty1, af1, ae1;
  logic [PW:0]   count0, count1;
`ifdef FIFO_ERR_FLAGS_EN
  logic          ovf0, unf0, ovf1, unf1;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout0 = '0;
  bit            exp_ovf = 1'b0;
  bit            exp_unf = 1'b0;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW),
                    .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf0), .underflow(unf0)
`endif
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW),
                    .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf1), .underflow(unf1)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue that accepts writes unless it holds DEPTH words
  // and accepts reads unless it is empty, judged on the occupancy before the edge.
  always @(posedge clk) begin
    int sz;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      exp_dout0 = '0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      if (w_en && sz == DEPTH) exp_ovf = 1'b1;
      if (r_en && sz == 0)     exp_unf = 1'b1;
      if (r_en && sz > 0)      exp_dout0 = exp_q.pop_front();
      if (w_en && sz < DEPTH)  exp_q.push_back(data_in);
    end
  end

  // Compare both instances against the model on every negedge.
  always @(negedge clk) begin
    int sz;
    if (cmp_en) begin
      sz = exp_q.size();
      check("count0", 32'(count0), 32'(sz));
      check("empty0", 32'(empty0), 32'(sz == 0));
      check("full0",  32'(full0),  32'(sz == DEPTH));
      check("af0",    32'(af0),    32'(sz >= AF));
      check("ae0",    32'(ae0),    32'(sz <= AE));
      check("dout0",  32'(dout0),  32'(exp_dout0));
      check("count1", 32'(count1), 32'(sz));
      check("empty1", 32'(empty1), 32'(sz == 0));
      check("full1",  32'(full1),  32'(sz == DEPTH));
      check("af1",    32'(af1),    32'(sz >= AF));
      check("ae1",    32'(ae1),    32'(sz <= AE));
      if (sz > 0) check("dout1", 32'(dout1), 32'(exp_q[0]));
`ifdef FIFO_ERR_FLAGS_EN
      check("ovf0", 32'(ovf0), 32'(exp_ovf));
      check("unf0", 32'(unf0), 32'(exp_unf));
      check("ovf1", 32'(ovf1), 32'(exp_ovf));
      check("unf1", 32'(unf1), 32'(exp_unf));
`endif
    end
  end

  // Driver tasks. Inputs change at a negedge; the task returns at the next
  // negedge, where the outputs reflect the edge in between.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    w_en    = w;
    data_in = d;
    r_en    = r;
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_count", 32'(count0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_full",  32'(full0),  32'd0);
    check("rst_ae",    32'(ae0),    32'd1);
    check("rst_af",    32'(af0),    32'd0);
    check("rst_dout",  32'(dout0),  32'd0);
    check("rst_empty1", 32'(empty1), 32'd1);
  endtask

  initial begin
    int written;
    int guard;
    int sz;
    bit w;
    bit r;

    @(negedge clk);
    do_reset();
    cmp_en = 1'b1;
    check_reset_state();

    // Fill with 0x10..0x17, then try a ninth write
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(8'h10 + i), 1'b0);
      check("fill_count", 32'(count0), 32'(i + 1));
      if (i == 4) check("af_at5", 32'(af0), 32'd0);
      if (i == 5) check("af_at6", 32'(af0), 32'd1);
    end
    check("fill_full", 32'(full0), 32'd1);
    step(1'b1, 8'hFF, 1'b0);
    check("ninth_count", 32'(count0), 32'd8);

    // Drain: each word appears the cycle after its r_en
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      check("drain_dout", 32'(dout0), 32'(8'h10 + i));
      if (i == 6) check("ae_at1", 32'(ae0), 32'd1);
      if (i == 5) check("ae_at2", 32'(ae0), 32'd0);
    end
    check("drain_empty", 32'(empty0), 32'd1);

    // FWFT: a written word is visible right after its write edge
    step(1'b1, 8'hA5, 1'b0);
    check("fwft_dout", 32'(dout1), 32'hA5);
    check("fwft_empty", 32'(empty1), 32'd0);
    step(1'b0, '0, 1'b1);
    check("fwft_pop_empty", 32'(empty1), 32'd1);
    check("reg_dout_a5", 32'(dout0), 32'hA5);

    // Simultaneous access at count 4
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h20 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(8'h30 + i), 1'b1);
      check("simul_count", 32'(count0), 32'd4);
    end
    check("simul_dout", 32'(dout0), 32'h30);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      check("simul_drain", 32'(dout0), 32'(8'h31 + i));
    end

    // Full with w_en and r_en together: read accepted, write dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h50 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    check("full_rw_count", 32'(count0), 32'd7);
    check("full_rw_dout", 32'(dout0), 32'h50);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1);
    check("full_rw_last", 32'(dout0), 32'h57);

    // Wrap-around: 20 words with occupancy held at 1..3
    step(1'b1, 8'h40, 1'b0);
    written = 1;
    guard = 0;
    while ((written < 20 || exp_q.size() > 0) && guard < 300) begin
      sz = exp_q.size();
      w = (written < 20) && (sz < 3) && ($urandom_range(0, 3) != 0);
      r = (sz >= 2 && $urandom_range(0, 1) == 1) ||
          (sz == 1 && w && $urandom_range(0, 1) == 1) ||
          (written == 20 && sz > 0);
      step(w, DW'(8'h40 + written), r);
      if (w) written++;
      guard++;
    end
    check("wrap_done", 32'(guard < 300), 32'd1);
    check("wrap_last", 32'(dout0), 32'h53);

`ifdef FIFO_ERR_FLAGS_EN
    // Error flags: underflow, then overflow, then reset clears both
    do_reset();
    step(1'b0, '0, 1'b1);
    check("unf_set", 32'(unf0), 32'd1);
    check("unf_count", 32'(count0), 32'd0);
    step(1'b0, '0, 1'b0);
    check("unf_sticky", 32'(unf0), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h60 + i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    check("ovf_set", 32'(ovf0), 32'd1);
    check("ovf_count", 32'(count0), 32'd8);
    do_reset();
    check("ovf_clr", 32'(ovf0), 32'd0);
    check("unf_clr", 32'(unf0), 32'd0);
`endif

    // Random traffic with occasional mid-operation reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else if (i % 200 < 100) begin
        step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) == 0);
      end else begin
        step($urandom_range(0, 3) == 0, DW'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    // Reset after traffic
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();
    check_reset_state();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
